// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
//   - Write-back select encodings (WB_*) as seen in the E stage.
//   - Forwarding select encodings (FWD_*) driven to the EX operand muxes.
//   - Controller FSM state type.
package hazard_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StError   = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the datapath and the hazard controller.
//   Datapath -> controller: stage register indices, write enables, write-back
//     select, E-stage redirect, M-stage memory request/ready.
//   Controller -> datapath: Stall*/Flush* pipeline-register controls, EX
//     forwarding selects, sticky timeout error, performance counters.
// Modports:
//   master - the hazard controller (drives every stall/flush/forward signal).
//   slave  - the datapath side.
interface hazard_ctrl_if;

    logic [4:0]  rs1_D;
    logic [4:0]  rs2_D;
    logic [4:0]  rs1_E;
    logic [4:0]  rs2_E;
    logic [4:0]  rd_E;
    logic [4:0]  rd_M;
    logic [4:0]  rd_W;
    logic        write_enable_RF_E;
    logic        write_enable_RF_M;
    logic        write_enable_RF_W;
    logic [1:0]  write_back_E;
    logic        pc_src_E;
    logic        dmem_req_M;
    logic        dmem_ready_M;

    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        StallM;
    logic        FlushD;
    logic        FlushE;
    logic        FlushW;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        mem_timeout_err;
    logic [31:0] load_use_cnt;
    logic [31:0] mem_wait_cnt;
    logic [31:0] redirect_cnt;

    modport master (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  write_enable_RF_E, write_enable_RF_M, write_enable_RF_W,
        input  write_back_E, pc_src_E, dmem_req_M, dmem_ready_M,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_timeout_err,
        output load_use_cnt, mem_wait_cnt, redirect_cnt
    );

    modport slave (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output write_enable_RF_E, write_enable_RF_M, write_enable_RF_W,
        output write_back_E, pc_src_E, dmem_req_M, dmem_ready_M,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_timeout_err,
        input  load_use_cnt, mem_wait_cnt, redirect_cnt
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX-stage forwarding select for one source operand.
// Ports:
//   rs_e_i          - source register of the instruction in E
//   rd_m_i, we_m_i  - destination / write enable of the instruction in M
//   rd_w_i, we_w_i  - destination / write enable of the instruction in W
//   fwd_o           - FWD_M, FWD_W or FWD_RF; M wins over W (younger value)
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       we_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       we_w_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        // x0 is never a real producer, so it must not forward.
        if (we_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (we_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage pipeline.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset; while high all stalls are 0,
//         FlushD/E/W are 1 and forwarding selects are register-file
//   hz  - hazard_ctrl_if.master bundle (stage info in, controls out)
// Parameters:
//   MEM_TIMEOUT - consecutive memory-wait cycles that trip the watchdog (>= 2)
//   TO_W        - wait-counter width; 2**TO_W must exceed MEM_TIMEOUT
// Build option:
//   HAZARD_PERF_CNT_EN - when defined, builds three 32-bit wrapping counters
//   (load-use bubbles, freeze cycles, redirects); otherwise the counter
//   outputs are tied to 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.master hz
);

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(MEM_TIMEOUT);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic       lu;
    logic       mw;
    logic       resolve;       // RUN-style priority rules apply this cycle
    logic       freeze;        // whole pipe held while memory is busy
    logic       stall_all;     // watchdog tripped
    logic       redirect_fire;
    logic       lu_fire;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    hazard_fwd_unit u_fwd_a (
        .rs_e_i (hz.rs1_E),
        .rd_m_i (hz.rd_M),
        .we_m_i (hz.write_enable_RF_M),
        .rd_w_i (hz.rd_W),
        .we_w_i (hz.write_enable_RF_W),
        .fwd_o  (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .rs_e_i (hz.rs2_E),
        .rd_m_i (hz.rd_M),
        .we_m_i (hz.write_enable_RF_M),
        .rd_w_i (hz.rd_W),
        .we_w_i (hz.write_enable_RF_W),
        .fwd_o  (fwd_b)
    );

    assign lu = hz.write_enable_RF_E && (hz.write_back_E == WB_MEM) && (hz.rd_E != 5'd0) &&
                ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
    assign mw = hz.dmem_req_M && !hz.dmem_ready_M;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resolve   = 1'b0;
        freeze    = 1'b0;
        stall_all = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mw) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    cnt_d   = TO_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            StMemWait: begin
                // Once in the wait, only ready matters; the request is held by the freeze.
                if (!hz.dmem_ready_M) begin
                    freeze = 1'b1;
                    if (cnt_q != TimeoutVal) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d >= TimeoutVal) begin
                        state_d = StError;
                    end
                end else begin
                    resolve = 1'b1;
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StError: begin
                stall_all = 1'b1;
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    // Redirect squashes the load-use consumer, so it takes priority.
    assign redirect_fire = resolve && hz.pc_src_E;
    assign lu_fire       = resolve && !hz.pc_src_E && lu;

    always_comb begin
        hz.StallF          = freeze | stall_all | lu_fire;
        hz.StallD          = freeze | stall_all | lu_fire;
        hz.StallE          = freeze | stall_all;
        hz.StallM          = freeze | stall_all;
        hz.FlushD          = redirect_fire;
        hz.FlushE          = redirect_fire | lu_fire;
        hz.FlushW          = freeze;
        hz.ForwardAE       = fwd_a;
        hz.ForwardBE       = fwd_b;
        hz.mem_timeout_err = (state_q == StError);
        if (rst) begin
            hz.StallF          = 1'b0;
            hz.StallD          = 1'b0;
            hz.StallE          = 1'b0;
            hz.StallM          = 1'b0;
            hz.FlushD          = 1'b1;
            hz.FlushE          = 1'b1;
            hz.FlushW          = 1'b1;
            hz.ForwardAE       = FWD_RF;
            hz.ForwardBE       = FWD_RF;
            hz.mem_timeout_err = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] mw_cnt_q;
    logic [31:0] rd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_q + 32'(lu_fire);
            mw_cnt_q <= mw_cnt_q + 32'(freeze);
            rd_cnt_q <= rd_cnt_q + 32'(redirect_fire);
        end
    end

    assign hz.load_use_cnt = lu_cnt_q;
    assign hz.mem_wait_cnt = mw_cnt_q;
    assign hz.redirect_cnt = rd_cnt_q;
`else
    assign hz.load_use_cnt = 32'd0;
    assign hz.mem_wait_cnt = 32'd0;
    assign hz.redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MEM_TIMEOUT = 8).
// The driver applies one stimulus per cycle just after the rising edge and
// pushes the reference model's expectation; the monitor pops and compares on
// the falling edge. Directed test-plan scenarios run first, then random traffic.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       we_e, we_m, we_w;
        logic [1:0] wb_e;
        logic       pc_src, req, rdy;
    } stim_t;

    typedef struct {
        logic [11:0] ctrl;  // {StallF,D,E,M, FlushD,E,W, FwdA, FwdB, err}
        logic [95:0] cnts;  // {load_use, mem_wait, redirect}
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT),
        .TO_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.master)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Reference model: pipeline mode (run / waiting on memory / dead) plus
    // the number of wait cycles seen so far in the current memory access.
    typedef enum int {MRun, MWait, MDead} mmode_e;
    mmode_e      m_mode = MRun;
    int          m_waited = 0;
    int unsigned m_lu = 0, m_mw = 0, m_rd = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp,
                         input int c);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic wem, input logic [4:0] rdw,
                                           input logic wew);
        if (wem && rdm != 0 && rdm == rs) return 2'b10;
        if (wew && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   hazard_lu, freeze, dead, redir, lu_b;
        logic [1:0] fa, fb;
        @(posedge clk);
        #1;
        cyc++;
        rst                   = s.rst;
        hif.rs1_D             = s.rs1_d;
        hif.rs2_D             = s.rs2_d;
        hif.rs1_E             = s.rs1_e;
        hif.rs2_E             = s.rs2_e;
        hif.rd_E              = s.rd_e;
        hif.rd_M              = s.rd_m;
        hif.rd_W              = s.rd_w;
        hif.write_enable_RF_E = s.we_e;
        hif.write_enable_RF_M = s.we_m;
        hif.write_enable_RF_W = s.we_w;
        hif.write_back_E      = s.wb_e;
        hif.pc_src_E          = s.pc_src;
        hif.dmem_req_M        = s.req;
        hif.dmem_ready_M      = s.rdy;

        e.cyc = cyc;
        if (s.rst) begin
            m_mode = MRun; m_waited = 0; m_lu = 0; m_mw = 0; m_rd = 0;
            e.ctrl = 12'b0000_111_00_00_0;
            e.cnts = '0;
            exp_q.push_back(e);
            return;
        end
`ifdef HAZARD_PERF_CNT_EN
        e.cnts = {m_lu, m_mw, m_rd};
`else
        e.cnts = '0;
`endif
        hazard_lu = s.we_e && s.wb_e == WB_MEM && s.rd_e != 0 &&
                    (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
        fa = ref_fwd(s.rs1_e, s.rd_m, s.we_m, s.rd_w, s.we_w);
        fb = ref_fwd(s.rs2_e, s.rd_m, s.we_m, s.rd_w, s.we_w);
        dead   = (m_mode == MDead);
        freeze = !dead && !s.rdy && (m_mode == MWait || s.req);
        redir  = !dead && !freeze && s.pc_src;
        lu_b   = !dead && !freeze && !s.pc_src && hazard_lu;
        e.ctrl = {freeze | dead | lu_b, freeze | dead | lu_b, freeze | dead, freeze | dead,
                  redir, redir | lu_b, freeze, fa, fb, dead};
        exp_q.push_back(e);

        if (freeze) begin
            m_waited++;
            m_mode = (m_waited >= int'(TIMEOUT)) ? MDead : MWait;
        end else if (!dead) begin
            m_mode   = MRun;
            m_waited = 0;
        end
        m_lu += lu_b ? 1 : 0;
        m_mw += freeze ? 1 : 0;
        m_rd += redir ? 1 : 0;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl", 96'({hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD,
                               hif.FlushE, hif.FlushW, hif.ForwardAE, hif.ForwardBE,
                               hif.mem_timeout_err}), 96'(e.ctrl), e.cyc);
            check("perf_cnts", {hif.load_use_cnt, hif.mem_wait_cnt, hif.redirect_cnt},
                  e.cnts, e.cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        hif.rs1_D = '0; hif.rs2_D = '0; hif.rs1_E = '0; hif.rs2_E = '0;
        hif.rd_E = '0; hif.rd_M = '0; hif.rd_W = '0;
        hif.write_enable_RF_E = 1'b0; hif.write_enable_RF_M = 1'b0;
        hif.write_enable_RF_W = 1'b0; hif.write_back_E = '0; hif.pc_src_E = 1'b0;
        hif.dmem_req_M = 1'b0; hif.dmem_ready_M = 1'b1;

        // Reset state
        s = idle(); s.rst = 1'b1;
        drive(s);
        #1 check("reset_flush", 96'({hif.FlushD, hif.FlushE, hif.FlushW}), 96'(3'b111), cyc);
        drive(s);
        s = idle();
        drive(s);

        // Forwarding: M has priority, x0 never forwards
        s.rd_m = 5; s.we_m = 1; s.rd_w = 5; s.we_w = 1; s.rs1_e = 5;
        drive(s);
        #1 check("fwd_m_prio", 96'(hif.ForwardAE), 96'(2'b10), cyc);
        s.rd_m = 0;
        drive(s);
        #1 check("fwd_w", 96'(hif.ForwardAE), 96'(2'b01), cyc);

        // Load-use: single bubble, then clear
        s = idle(); s.wb_e = WB_MEM; s.we_e = 1; s.rd_e = 3; s.rs2_d = 3;
        drive(s);
        #1 check("lu_bubble", 96'({hif.StallF, hif.StallD, hif.FlushE}), 96'(3'b111), cyc);
        drive(idle());
        #1 check("lu_clear", 96'({hif.StallF, hif.StallD, hif.FlushE}), 96'(3'b000), cyc);

        // Redirect beats a simultaneous load-use
        s.pc_src = 1;
        drive(s);
        #1 check("redirect_over_lu", 96'({hif.FlushD, hif.FlushE, hif.StallF, hif.StallD}),
                 96'(4'b1100), cyc);

        // Memory wait: 4 frozen cycles then release
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (4) begin
            drive(s);
            #1 check("mw_freeze", 96'({hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                                      hif.FlushW}), 96'(5'b11111), cyc);
        end
        s.rdy = 1;
        drive(s);
        #1 check("mw_release", 96'({hif.StallM, hif.FlushW}), 96'(2'b00), cyc);
        drive(idle());

        // Timeout after 8 wait cycles, sticky until reset
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (TIMEOUT) drive(s);
        s.rdy = 1;
        drive(s);
        #1 check("timeout_err", 96'({hif.mem_timeout_err, hif.StallF, hif.StallM, hif.FlushW}),
                 96'(4'b1110), cyc);
        drive(idle());
        s = idle(); s.rst = 1;
        drive(s);
        drive(idle());
        #1 check("err_cleared", 96'(hif.mem_timeout_err), 96'(1'b0), cyc);

        // Three load-use events then counter readback
        repeat (3) begin
            s = idle(); s.wb_e = WB_MEM; s.we_e = 1; s.rd_e = 7; s.rs1_d = 7;
            drive(s);
            drive(idle());
        end
`ifdef HAZARD_PERF_CNT_EN
        #1 check("lu_cnt3", 96'(hif.load_use_cnt), 96'(3), cyc);
`else
        #1 check("lu_cnt_tied", 96'(hif.load_use_cnt), 96'(0), cyc);
`endif

        // Async reset in the middle of a memory wait
        s = idle(); s.req = 1; s.rdy = 0;
        drive(s);
        drive(s);
        s.rst = 1;
        drive(s);
        #1 check("async_rst", 96'({hif.FlushD, hif.FlushE, hif.FlushW, hif.StallF,
                                  hif.load_use_cnt}), {64'd0, 3'b111, 1'b0, 32'd0}, cyc);
        drive(idle());

        // Random traffic
        repeat (600) begin
            s        = idle();
            s.rst    = ($urandom_range(0, 99) < 2);
            s.rs1_d  = 5'($urandom_range(0, 3));
            s.rs2_d  = 5'($urandom_range(0, 3));
            s.rs1_e  = 5'($urandom_range(0, 3));
            s.rs2_e  = 5'($urandom_range(0, 3));
            s.rd_e   = 5'($urandom_range(0, 3));
            s.rd_m   = 5'($urandom_range(0, 3));
            s.rd_w   = 5'($urandom_range(0, 3));
            s.we_e   = 1'($urandom);
            s.we_m   = 1'($urandom);
            s.we_w   = 1'($urandom);
            s.wb_e   = 2'($urandom);
            s.pc_src = ($urandom_range(0, 99) < 15);
            s.req    = ($urandom_range(0, 99) < 30);
            s.rdy    = ($urandom_range(0, 99) < 60);
            drive(s);
        end

        drive(idle());
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control for the 5-stage RISC-V core.
- Produces the stall and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus EX-stage operand forwarding selects.
- Detects load-use hazards and E-stage redirects (mispredicted branch or jump).
- Sequences multi-cycle data-memory waits with a timeout watchdog. Sits beside the datapath; it is the driver of every StallX/FlushX pipeline-register input.

Parameters:
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before an error is raised (at least 2).
- TO_W, 8, width of the wait counter (2^TO_W must be greater than MEM_TIMEOUT).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- rs1_D, rs2_D  in  5  source registers of the instruction in D.
- rs1_E, rs2_E  in  5  source registers of the instruction in E.
- rd_E, rd_M, rd_W  in  5  destination registers of the instructions in E, M and W.
- write_enable_RF_E/M/W  in  1  register-file write enable for each stage.
- write_back_E  in  2  write-back select in E; WB_MEM = 2'b01 marks a load.
- pc_src_E  in  1  redirect resolved in E (taken-mismatch or jump).
- dmem_req_M  in  1  data-memory access active in M.
- dmem_ready_M  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1  insert a bubble into IF/ID, ID/EX and MEM/WB.
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- mem_timeout_err  out  1  sticky watchdog error.
- load_use_cnt, mem_wait_cnt, redirect_cnt  out  32  performance counters (see Optional Feature).

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset value: RUN, wait counter 0, mem_timeout_err 0, all perf counters 0.
- While rst is high, outputs are forced:
  - Stall* = 0.
  - FlushD = FlushE = FlushW = 1.
  - Forward* = 00.
- All outputs are combinational from state plus inputs, with zero latency.
- Forwarding for A (B is identical, using rs2_E):
  - 10 if write_enable_RF_M, rd_M != 0 and rd_M == rs1_E.
  - Else 01 if write_enable_RF_W, rd_W != 0 and rd_W == rs1_E.
  - Else 00.
  - M has priority over W. Forwarding is computed in every state.
- lu (load-use) = write_enable_RF_E & (write_back_E == WB_MEM) & (rd_E != 0) & (rd_E == rs1_D | rd_E == rs2_D).
- mw (memory wait) = dmem_req_M & !dmem_ready_M.
- RUN state, first matching rule applies:
  1. mw: StallF, StallD, StallE, StallM, FlushW = 1; no other flush. Next state MEM_WAIT; counter = 1. Any pending redirect or load-use is deferred because its stage contents are frozen.
  2. pc_src_E: FlushD = FlushE = 1, no stalls. Redirect overrides a simultaneous lu, because the load-use consumer is squashed.
  3. lu: StallF = StallD = 1, FlushE = 1. Exactly one bubble per lu cycle.
  4. Otherwise all controls are 0.
- MEM_WAIT state:
  - While dmem_ready_M = 0: same freeze as RUN rule 1; counter increments.
  - When dmem_ready_M = 1: outputs are evaluated with RUN rules 2–4 this cycle; next state RUN; counter cleared.
  - If the counter reaches MEM_TIMEOUT while ready is still 0: next state ERROR.
- ERROR state:
  - mem_timeout_err = 1 and all Stall* = 1, held until rst.
  - Flushes 0. dmem_ready_M is ignored.
- The wait counter saturates at MEM_TIMEOUT and never wraps.
- Asserting rst at any time, including mid-MEM_WAIT, returns immediately to RUN with counters cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, each incremented by 1 per clock:
  - load_use_cnt: cycles where RUN rule 3 fires.
  - mem_wait_cnt: cycles where the freeze is asserted.
  - redirect_cnt: cycles where rule 2 fires.
- Not defined: ports remain, tied to 0, and no counter flops are built.

Decomposition:
- Package hazard_pkg:
  - WB_ALU/WB_MEM/WB_PC4 encodings.
  - FWD_RF/FWD_W/FWD_M encodings.
  - FSM state enum (RUN, MEM_WAIT, ERROR).
- Sub-module hazard_fwd_unit: combinational forwarding for one operand, instantiated twice (A and B).
- FSM, hazard detection and counters stay in the top module.

Test Plan:
- Forwarding:
  - rd_M = 5, we_M = 1, rd_W = 5, we_W = 1, rs1_E = 5 -> ForwardAE = 10.
  - Same but rd_M = 0 -> ForwardAE = 01.
- Load-use: write_back_E = 01, we_E = 1, rd_E = 3, rs2_D = 3 -> StallF = StallD = FlushE = 1 for exactly 1 cycle; next cycle all 0.
- Redirect with simultaneous lu: pc_src_E = 1 together with the lu condition -> FlushD = FlushE = 1, StallF = StallD = 0.
- Memory wait: dmem_req_M = 1, ready low for 4 cycles then high -> Stall F/D/E/M and FlushW high for 4 cycles, RUN on the 5th.
- Timeout: MEM_TIMEOUT = 8, ready never asserted -> mem_timeout_err = 1 after the 8th wait cycle, all stalls stuck at 1; rst pulse clears the error and returns to RUN.
- Async reset mid-MEM_WAIT, plus perf counters: with HAZARD_PERF_CNT_EN defined, 3 lu events give load_use_cnt = 3; rst asserted between clock edges clears the counters and forces FlushD/E/W = 1 immediately.
